// File: rtl/onchip_sram_pkg.sv
// Shared definitions for the dual-port scratch SRAM.
//  - fsm_state_t: controller states (RUN serves traffic, CLEAR fills the array)
//  - read_latency_legal(): only 1- or 2-cycle read pipelines are built
//  - byte_lanes(): number of byte enables for a given word width
package onchip_sram_pkg;

    typedef enum logic {
        RUN   = 1'b0,
        CLEAR = 1'b1
    } fsm_state_t;

    function automatic bit read_latency_legal(input int latency);
        return (latency == 1) || (latency == 2);
    endfunction

    function automatic int byte_lanes(input int data_width);
        return data_width / 8;
    endfunction

endpackage

// File: rtl/sram_dp_core.sv
// Behavioural byte-enabled true-dual-port array with a registered read port
// on each side.
//  clk, reset          single clock; reset clears only the read registers
//  a_* / b_*           write enable, read enable, word address, byte enables,
//                      write data, registered read data
// A word at an address >= DEPTH is never written and always reads as 0.
// Reads are write-first: a read sees the word as it will be after this
// cycle's writes. When both ports write one address, port a owns every lane
// it enables and port b fills only the lanes port a leaves alone.
module sram_dp_core
    import onchip_sram_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 10,
    parameter int DEPTH      = 1024
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    a_we,
    input  logic                    a_re,
    input  logic [ADDR_WIDTH-1:0]   a_addr,
    input  logic [DATA_WIDTH/8-1:0] a_be,
    input  logic [DATA_WIDTH-1:0]   a_wdata,
    output logic [DATA_WIDTH-1:0]   a_rdata,
    input  logic                    b_we,
    input  logic                    b_re,
    input  logic [ADDR_WIDTH-1:0]   b_addr,
    input  logic [DATA_WIDTH/8-1:0] b_be,
    input  logic [DATA_WIDTH-1:0]   b_wdata,
    output logic [DATA_WIDTH-1:0]   b_rdata
);

    localparam int NB = byte_lanes(DATA_WIDTH);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic                  a_in, b_in;
    logic [DATA_WIDTH-1:0] a_post, b_post;

    function automatic logic [DATA_WIDTH-1:0] apply_lanes(
        input logic [DATA_WIDTH-1:0] base,
        input logic [NB-1:0]         be,
        input logic [DATA_WIDTH-1:0] wdata
    );
        logic [DATA_WIDTH-1:0] r;
        r = base;
        for (int i = 0; i < NB; i++) begin
            if (be[i]) r[8*i +: 8] = wdata[8*i +: 8];
        end
        return r;
    endfunction

    assign a_in = (32'(a_addr) < 32'(DEPTH));
    assign b_in = (32'(b_addr) < 32'(DEPTH));

    // Post-write word at each port's address. Port b's lanes go on first so
    // port a's overlapping lanes overwrite them.
    always_comb begin
        a_post = '0;
        b_post = '0;
        if (a_in) begin
            a_post = mem[a_addr];
            if (b_we && b_in && (b_addr == a_addr)) a_post = apply_lanes(a_post, b_be, b_wdata);
            if (a_we) a_post = apply_lanes(a_post, a_be, a_wdata);
        end
        if (b_in) begin
            b_post = mem[b_addr];
            if (b_we) b_post = apply_lanes(b_post, b_be, b_wdata);
            if (a_we && a_in && (a_addr == b_addr)) b_post = apply_lanes(b_post, a_be, a_wdata);
        end
    end

    // Both ports store the fully merged word, so a same-address dual write
    // stores one identical value twice.
    always_ff @(posedge clk) begin
        if (a_we && a_in) mem[a_addr] <= a_post;
        if (b_we && b_in) mem[b_addr] <= b_post;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            a_rdata <= '0;
            b_rdata <= '0;
        end else begin
            if (a_re) a_rdata <= a_post;
            if (b_re) b_rdata <= b_post;
        end
    end

endmodule

// File: rtl/onchip_sram_dp_clr.sv
// Shared HPS/FPGA scratch SRAM: two Avalon-MM slaves (s1, s2) on one clock
// with a clear engine that fills the array with CLEAR_VALUE.
//  clk, reset             single clock, synchronous active-high reset
//  sN_address/byteenable/chipselect/read/write/writedata   slave requests
//  sN_readdata/readdatavalid   read response, READ_LATENCY cycles after accept
//  sN_waitrequest         high while reset is held or the clear engine runs
//  clear_req              pulse to start a clear from RUN
//  init_busy              high while the clear engine runs
module onchip_sram_dp_clr
    import onchip_sram_pkg::*;
#(
    parameter int                    DATA_WIDTH     = 32,
    parameter int                    ADDR_WIDTH     = 10,
    parameter int                    DEPTH          = 1024,
    parameter int                    READ_LATENCY   = 1,
    parameter int                    CLEAR_ON_RESET = 1,
    parameter logic [DATA_WIDTH-1:0] CLEAR_VALUE    = '0
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [ADDR_WIDTH-1:0]   s1_address,
    input  logic [DATA_WIDTH/8-1:0] s1_byteenable,
    input  logic                    s1_chipselect,
    input  logic                    s1_read,
    input  logic                    s1_write,
    input  logic [DATA_WIDTH-1:0]   s1_writedata,
    output logic [DATA_WIDTH-1:0]   s1_readdata,
    output logic                    s1_readdatavalid,
    output logic                    s1_waitrequest,
    input  logic [ADDR_WIDTH-1:0]   s2_address,
    input  logic [DATA_WIDTH/8-1:0] s2_byteenable,
    input  logic                    s2_chipselect,
    input  logic                    s2_read,
    input  logic                    s2_write,
    input  logic [DATA_WIDTH-1:0]   s2_writedata,
    output logic [DATA_WIDTH-1:0]   s2_readdata,
    output logic                    s2_readdatavalid,
    output logic                    s2_waitrequest,
    input  logic                    clear_req,
    output logic                    init_busy
);

    if (!read_latency_legal(READ_LATENCY)) begin : g_bad_latency
        $error("onchip_sram_dp_clr: READ_LATENCY must be 1 or 2");
    end

    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR   = ADDR_WIDTH'(DEPTH - 1);
    localparam fsm_state_t            RESET_STATE = (CLEAR_ON_RESET != 0) ? CLEAR : RUN;

    fsm_state_t            state;
    logic [ADDR_WIDTH-1:0] clear_addr;
    logic                  wait_q, busy_q;
    logic                  clearing;
    logic                  s1_wr_acc, s1_rd_acc, s2_wr_acc, s2_rd_acc;
    logic                  core_a_we;
    logic [ADDR_WIDTH-1:0] core_a_addr;
    logic [DATA_WIDTH/8-1:0] core_a_be;
    logic [DATA_WIDTH-1:0] core_a_wdata;
    logic [DATA_WIDTH-1:0] core_a_rdata, core_b_rdata;
    logic                  s1_rdv1, s2_rdv1;

    // waitrequest/init_busy are registered from the next state, so they rise
    // the cycle after clear_req and fall in the cycle after the last clear write.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= RESET_STATE;
            clear_addr <= '0;
            wait_q     <= 1'b1;
            busy_q     <= (CLEAR_ON_RESET != 0);
        end else begin
            case (state)
                RUN: begin
                    if (clear_req) begin
                        state      <= CLEAR;
                        clear_addr <= '0;
                        wait_q     <= 1'b1;
                        busy_q     <= 1'b1;
                    end else begin
                        wait_q <= 1'b0;
                        busy_q <= 1'b0;
                    end
                end
                CLEAR: begin
                    if (clear_addr == LAST_ADDR) begin
                        state  <= RUN;
                        wait_q <= 1'b0;
                        busy_q <= 1'b0;
                    end else begin
                        clear_addr <= clear_addr + 1'b1;
                        wait_q     <= 1'b1;
                        busy_q     <= 1'b1;
                    end
                end
                default: begin
                    state  <= RUN;
                    wait_q <= 1'b0;
                    busy_q <= 1'b0;
                end
            endcase
        end
    end

    assign s1_waitrequest = wait_q;
    assign s2_waitrequest = wait_q;
    assign init_busy      = busy_q;

    // A read with write also high is a write only. Reset drops any request
    // presented in the same cycle.
    assign s1_wr_acc = s1_chipselect & s1_write & ~wait_q & ~reset;
    assign s1_rd_acc = s1_chipselect & s1_read & ~s1_write & ~wait_q & ~reset;
    assign s2_wr_acc = s2_chipselect & s2_write & ~wait_q & ~reset;
    assign s2_rd_acc = s2_chipselect & s2_read & ~s2_write & ~wait_q & ~reset;

    // The clear engine borrows port a; s1 is held off by waitrequest meanwhile.
    assign clearing     = (state == CLEAR) & ~reset;
    assign core_a_we    = clearing | s1_wr_acc;
    assign core_a_addr  = clearing ? clear_addr  : s1_address;
    assign core_a_be    = clearing ? '1          : s1_byteenable;
    assign core_a_wdata = clearing ? CLEAR_VALUE : s1_writedata;

    sram_dp_core #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH),
        .DEPTH      (DEPTH)
    ) u_core (
        .clk     (clk),
        .reset   (reset),
        .a_we    (core_a_we),
        .a_re    (s1_rd_acc),
        .a_addr  (core_a_addr),
        .a_be    (core_a_be),
        .a_wdata (core_a_wdata),
        .a_rdata (core_a_rdata),
        .b_we    (s2_wr_acc),
        .b_re    (s2_rd_acc),
        .b_addr  (s2_address),
        .b_be    (s2_byteenable),
        .b_wdata (s2_writedata),
        .b_rdata (core_b_rdata)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            s1_rdv1 <= 1'b0;
            s2_rdv1 <= 1'b0;
        end else begin
            s1_rdv1 <= s1_rd_acc;
            s2_rdv1 <= s2_rd_acc;
        end
    end

    if (READ_LATENCY == 2) begin : g_lat2
        logic [DATA_WIDTH-1:0] s1_data2, s2_data2;
        logic                  s1_rdv2, s2_rdv2;

        // Reset clears this stage too, so a read one cycle from completion
        // never produces readdatavalid.
        always_ff @(posedge clk) begin
            if (reset) begin
                s1_data2 <= '0;
                s2_data2 <= '0;
                s1_rdv2  <= 1'b0;
                s2_rdv2  <= 1'b0;
            end else begin
                s1_data2 <= core_a_rdata;
                s2_data2 <= core_b_rdata;
                s1_rdv2  <= s1_rdv1;
                s2_rdv2  <= s2_rdv1;
            end
        end

        assign s1_readdata      = s1_data2;
        assign s2_readdata      = s2_data2;
        assign s1_readdatavalid = s1_rdv2;
        assign s2_readdatavalid = s2_rdv2;
    end else begin : g_lat1
        assign s1_readdata      = core_a_rdata;
        assign s2_readdata      = core_b_rdata;
        assign s1_readdatavalid = s1_rdv1;
        assign s2_readdatavalid = s2_rdv1;
    end

endmodule
